// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS EX stage: operation codes,
// FSM state encoding and default datapath widths.
package mips_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int DEST_W_DEF = 5;
   localparam int SH_W_DEF   = 5;

   localparam logic [3:0] EXE_ADD = 4'b0000;
   localparam logic [3:0] EXE_SUB = 4'b0010;
   localparam logic [3:0] EXE_AND = 4'b0100;
   localparam logic [3:0] EXE_OR  = 4'b0101;
   localparam logic [3:0] EXE_NOR = 4'b0110;
   localparam logic [3:0] EXE_XOR = 4'b0111;
   localparam logic [3:0] EXE_SLL = 4'b1000;
   localparam logic [3:0] EXE_SRA = 4'b1001;
   localparam logic [3:0] EXE_SRL = 4'b1010;
   localparam logic [3:0] EXE_MUL = 4'b1100;

   typedef enum logic {ST_IDLE = 1'b0, ST_MULT = 1'b1} state_t;

endpackage

// File: rtl/exe_stage_mc_seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low WIDTH bits of a*b in WIDTH
// steps. Only present when EXE_MUL_EN is defined.
`ifdef EXE_MUL_EN
module seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_next;

   // The product is presented on the final step itself, so it includes that step's add.
   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
   assign o_product  = w_acc_next;
   assign o_done     = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_a    <= i_a;
         r_b    <= i_b;
         r_acc  <= '0;
      end else if (r_busy) begin
         r_acc <= w_acc_next;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_W'(WIDTH - 1)) r_busy <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/exe_stage_mc.sv
// EX stage of the multicycle MIPS pipeline: single-cycle ALU plus, when
// EXE_MUL_EN is defined, an iterative multiply that freezes ID/EX.
import mips_pkg::*;

module exe_stage_mc #(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DEST_W = DEST_W_DEF,
   parameter int SH_W   = SH_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [3:0]        EXE_CMD,
   input  logic [WIDTH-1:0]  Val1,
   input  logic [WIDTH-1:0]  Val2,
   input  logic [WIDTH-1:0]  Reg2,
   input  logic [DEST_W-1:0] Dest,
   input  logic [WIDTH-1:0]  PC_in,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic              WB_EN,
   output logic              freeze,
   output logic              out_valid,
   output logic [WIDTH-1:0]  ALU_Res,
   output logic [WIDTH-1:0]  Reg2_out,
   output logic [DEST_W-1:0] Dest_out,
   output logic [WIDTH-1:0]  PC_out,
   output logic              MEM_R_EN_out,
   output logic              MEM_W_EN_out,
   output logic              WB_EN_out
);

   logic [WIDTH-1:0]  w_alu;
   logic [SH_W-1:0]   w_sh;
   logic              w_accept;
   logic              w_wb;

   logic              r_valid;
   logic [WIDTH-1:0]  r_res;
   logic [WIDTH-1:0]  r_reg2;
   logic [DEST_W-1:0] r_dest;
   logic [WIDTH-1:0]  r_pc;
   logic              r_mr;
   logic              r_mw;
   logic              r_wb;

   assign w_sh = Val2[SH_W-1:0];

   always_comb begin
      w_alu = '0;
      case (EXE_CMD)
         EXE_ADD: w_alu = Val1 + Val2;
         EXE_SUB: w_alu = Val1 - Val2;
         EXE_AND: w_alu = Val1 & Val2;
         EXE_OR:  w_alu = Val1 | Val2;
         EXE_NOR: w_alu = ~(Val1 | Val2);
         EXE_XOR: w_alu = Val1 ^ Val2;
         EXE_SLL: w_alu = Val1 << w_sh;
         EXE_SRA: w_alu = WIDTH'($signed(Val1) >>> w_sh);
         EXE_SRL: w_alu = Val1 >> w_sh;
         default: w_alu = '0;
      endcase
   end

`ifdef EXE_MUL_EN
   state_t            r_state;
   logic              w_mul_start;
   logic              w_mul_done;
   logic [WIDTH-1:0]  w_mul_prod;
   logic [WIDTH-1:0]  r_m_reg2;
   logic [DEST_W-1:0] r_m_dest;
   logic [WIDTH-1:0]  r_m_pc;
   logic              r_m_mr;
   logic              r_m_mw;
   logic              r_m_wb;

   assign w_accept    = (r_state == ST_IDLE) && in_valid && !flush;
   assign w_mul_start = w_accept && (EXE_CMD == EXE_MUL);
   assign w_wb        = WB_EN;
   assign freeze      = (r_state == ST_MULT);

   seq_multiplier #(.WIDTH(WIDTH), .CNT_W(SH_W)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (Val1),
      .i_b       (Val2),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   // flush and in_valid are deliberately ignored in MULT: the multiply is older.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0; r_res <= '0; r_reg2 <= '0; r_dest <= '0; r_pc <= '0;
         r_mr     <= 1'b0; r_mw  <= 1'b0; r_wb <= 1'b0;
         r_m_reg2 <= '0; r_m_dest <= '0; r_m_pc <= '0;
         r_m_mr   <= 1'b0; r_m_mw <= 1'b0; r_m_wb <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mul_start) begin
                  r_state  <= ST_MULT;
                  r_m_reg2 <= Reg2; r_m_dest <= Dest; r_m_pc <= PC_in;
                  r_m_mr   <= MEM_R_EN; r_m_mw <= MEM_W_EN; r_m_wb <= WB_EN;
                  r_valid  <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_wb <= 1'b0;
               end else if (w_accept) begin
                  r_valid <= 1'b1; r_res <= w_alu; r_reg2 <= Reg2; r_dest <= Dest;
                  r_pc    <= PC_in; r_mr <= MEM_R_EN; r_mw <= MEM_W_EN; r_wb <= w_wb;
               end else begin
                  r_valid <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_wb <= 1'b0;
               end
            end
            ST_MULT: begin
               if (w_mul_done) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b1; r_res <= w_mul_prod; r_reg2 <= r_m_reg2;
                  r_dest  <= r_m_dest; r_pc <= r_m_pc;
                  r_mr    <= r_m_mr; r_mw <= r_m_mw; r_wb <= r_m_wb;
               end else begin
                  r_valid <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_wb <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
`else
   // Without the multiplier, MUL falls through as a NOP that must not write back.
   assign w_accept = in_valid && !flush;
   assign w_wb     = WB_EN && (EXE_CMD != EXE_MUL);
   assign freeze   = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0; r_res <= '0; r_reg2 <= '0; r_dest <= '0; r_pc <= '0;
         r_mr    <= 1'b0; r_mw  <= 1'b0; r_wb <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1; r_res <= w_alu; r_reg2 <= Reg2; r_dest <= Dest;
         r_pc    <= PC_in; r_mr <= MEM_R_EN; r_mw <= MEM_W_EN; r_wb <= w_wb;
      end else begin
         r_valid <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_wb <= 1'b0;
      end
   end
`endif

   assign out_valid    = r_valid;
   assign ALU_Res      = r_res;
   assign Reg2_out     = r_reg2;
   assign Dest_out     = r_dest;
   assign PC_out       = r_pc;
   assign MEM_R_EN_out = r_mr;
   assign MEM_W_EN_out = r_mw;
   assign WB_EN_out    = r_wb;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed-vector bench for exe_stage_mc; multiply scenarios follow EXE_MUL_EN.
module tb_exe_stage_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [3:0]  EXE_CMD;
   logic [31:0] Val1;
   logic [31:0] Val2;
   logic [31:0] Reg2;
   logic [4:0]  Dest;
   logic [31:0] PC_in;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic        WB_EN;
   logic        freeze;
   logic        out_valid;
   logic [31:0] ALU_Res;
   logic [31:0] Reg2_out;
   logic [4:0]  Dest_out;
   logic [31:0] PC_out;
   logic        MEM_R_EN_out;
   logic        MEM_W_EN_out;
   logic        WB_EN_out;

   int n_vec = 0;
   int n_err = 0;

   exe_stage_mc dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .EXE_CMD(EXE_CMD),
      .Val1(Val1), .Val2(Val2), .Reg2(Reg2), .Dest(Dest), .PC_in(PC_in),
      .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
      .freeze(freeze), .out_valid(out_valid), .ALU_Res(ALU_Res), .Reg2_out(Reg2_out),
      .Dest_out(Dest_out), .PC_out(PC_out), .MEM_R_EN_out(MEM_R_EN_out),
      .MEM_W_EN_out(MEM_W_EN_out), .WB_EN_out(WB_EN_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic wb);
      in_valid = 1'b1; flush = 1'b0; EXE_CMD = cmd; Val1 = a; Val2 = b;
      Reg2 = a ^ b; Dest = d; PC_in = {a[15:0], b[15:0]}; WB_EN = wb;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; flush = 1'b0; EXE_CMD = 4'b0000; Val1 = '0; Val2 = '0;
      Reg2 = '0; Dest = '0; PC_in = '0; WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step(); step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      n_vec++; if (ALU_Res !== 32'h0) begin n_err++; $display("FAIL reset_res got %h exp 0", ALU_Res); end
      n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL reset_freeze got %b exp 0", freeze); end
      n_vec++; if ({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out} !== 3'b000) begin n_err++; $display("FAIL reset_en got %b exp 000", {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}); end
      n_vec++; if ({Dest_out, PC_out, Reg2_out} !== 69'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", {Dest_out, PC_out, Reg2_out}); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      issue(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1);
      MEM_W_EN = 1'b1;
      step();
      n_vec++; if (ALU_Res !== 32'd12) begin n_err++; $display("FAIL add_res got %h exp %h", ALU_Res, 32'd12); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", out_valid); end
      n_vec++; if (WB_EN_out !== 1'b1) begin n_err++; $display("FAIL add_wb got %b exp 1", WB_EN_out); end
      n_vec++; if (MEM_W_EN_out !== 1'b1) begin n_err++; $display("FAIL add_memw got %b exp 1", MEM_W_EN_out); end
      n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL add_freeze got %b exp 0", freeze); end
      n_vec++; if (Dest_out !== 5'd3) begin n_err++; $display("FAIL add_dest got %h exp 3", Dest_out); end
      n_vec++; if (PC_out !== 32'h0005_0007) begin n_err++; $display("FAIL add_pc got %h exp 00050007", PC_out); end
      n_vec++; if (Reg2_out !== 32'd2) begin n_err++; $display("FAIL add_reg2 got %h exp 2", Reg2_out); end
   endtask

   task automatic test_flush();
      // Previous result 12 must be held through bubbles.
      issue(4'b0000, 32'd100, 32'd1, 5'd9, 1'b1);
      flush = 1'b1;
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      n_vec++; if (WB_EN_out !== 1'b0) begin n_err++; $display("FAIL flush_wb got %b exp 0", WB_EN_out); end
      n_vec++; if (ALU_Res !== 32'd12) begin n_err++; $display("FAIL flush_hold got %h exp %h", ALU_Res, 32'd12); end
      n_vec++; if (Dest_out !== 5'd3) begin n_err++; $display("FAIL flush_dest_hold got %h exp 3", Dest_out); end
      idle_inputs();
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  t_cmd[11];
      logic [31:0] t_a[11];
      logic [31:0] t_b[11];
      logic [31:0] t_exp[11];
      t_cmd = '{4'b0010, 4'b1001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                4'b1000, 4'b1010, 4'b1001, 4'b0011, 4'b0000};
      t_a   = '{32'd3, 32'h8000_0000, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                32'h0000_0001, 32'h8000_0000, 32'h7000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
      t_b   = '{32'd5, 32'd4, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00,
                32'h0000_0025, 32'd31, 32'd4, 32'h1111_1111, 32'd2};
      t_exp = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h00F0_1200, 32'hFFF0_FF34, 32'h000F_00CB,
                32'hFF00_ED34, 32'h0000_0020, 32'h0000_0001, 32'h0700_0000, 32'h0, 32'h1};
      for (int i = 0; i < 11; i++) begin
         issue(t_cmd[i], t_a[i], t_b[i], 5'(i + 1), 1'b1);
         step();
         n_vec++; if (ALU_Res !== t_exp[i]) begin n_err++; $display("FAIL alu_%0d cmd %b got %h exp %h", i, t_cmd[i], ALU_Res, t_exp[i]); end
         n_vec++; if ({out_valid, WB_EN_out, freeze} !== 3'b110) begin n_err++; $display("FAIL alu_ctl_%0d got %b exp 110", i, {out_valid, WB_EN_out, freeze}); end
         n_vec++; if (Dest_out !== 5'(i + 1)) begin n_err++; $display("FAIL alu_dest_%0d got %0d exp %0d", i, Dest_out, i + 1); end
      end
      idle_inputs();
      step();
   endtask

`ifdef EXE_MUL_EN
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic pulse_flush);
      int fz;
      int early;
      int cyc;
      issue(4'b1100, a, b, 5'd17, 1'b1);
      step();
      // ID/EX now shows the next instruction (ADD 1+1), which must wait.
      issue(4'b0000, 32'd1, 32'd1, 5'd4, 1'b1);
      fz = 0; early = 0; cyc = 0;
      while (freeze === 1'b1 && cyc < 40) begin
         if (out_valid !== 1'b0) early++;
         fz++; cyc++;
         flush = pulse_flush && (cyc == 5);
         step();
      end
      flush = 1'b0;
      n_vec++; if (fz !== 32) begin n_err++; $display("FAIL %s_freeze_len got %0d exp 32", tag, fz); end
      n_vec++; if (early !== 0) begin n_err++; $display("FAIL %s_early_valid got %0d exp 0", tag, early); end
      n_vec++; if (ALU_Res !== exp) begin n_err++; $display("FAIL %s_prod got %h exp %h", tag, ALU_Res, exp); end
      n_vec++; if ({out_valid, WB_EN_out} !== 2'b11) begin n_err++; $display("FAIL %s_done_ctl got %b exp 11", tag, {out_valid, WB_EN_out}); end
      n_vec++; if (Dest_out !== 5'd17) begin n_err++; $display("FAIL %s_dest got %0d exp 17", tag, Dest_out); end
      n_vec++; if (PC_out !== {a[15:0], b[15:0]}) begin n_err++; $display("FAIL %s_pc got %h exp %h", tag, PC_out, {a[15:0], b[15:0]}); end
      step();
      n_vec++; if (ALU_Res !== 32'd2) begin n_err++; $display("FAIL %s_next_add got %h exp 2", tag, ALU_Res); end
      n_vec++; if ({out_valid, freeze, Dest_out} !== {2'b10, 5'd4}) begin n_err++; $display("FAIL %s_next_ctl got %b exp 1000100", tag, {out_valid, freeze, Dest_out}); end
      idle_inputs();
      step();
   endtask

   task automatic test_mul();
      run_mul("mul", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
      run_mul("mul_flush", 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b1);
      run_mul("mul_zero", 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
      run_mul("mul_neg", 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);
   endtask

   task automatic test_mul_reset();
      issue(4'b1100, 32'd6, 32'd7, 5'd8, 1'b1);
      step();
      idle_inputs();
      for (int i = 0; i < 10; i++) step();
      n_vec++; if (freeze !== 1'b1) begin n_err++; $display("FAIL mrst_busy got %b exp 1", freeze); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL mrst_freeze got %b exp 0", freeze); end
      n_vec++; if ({out_valid, WB_EN_out, ALU_Res, Dest_out} !== 39'h0) begin n_err++; $display("FAIL mrst_outs got %h exp 0", {out_valid, WB_EN_out, ALU_Res, Dest_out}); end
      issue(4'b0000, 32'd2, 32'd3, 5'd1, 1'b1);
      step();
      n_vec++; if ({out_valid, freeze, ALU_Res} !== {2'b10, 32'd5}) begin n_err++; $display("FAIL mrst_add got %h exp %h", {out_valid, freeze, ALU_Res}, {2'b10, 32'd5}); end
      idle_inputs();
      for (int i = 0; i < 40; i++) begin
         step();
         n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL mrst_ghost_%0d got %b exp 0", i, freeze); end
      end
   endtask
`else
   task automatic test_mul_disabled();
      int fz;
      issue(4'b1100, 32'd6, 32'd7, 5'd8, 1'b1);
      MEM_R_EN = 1'b1;
      step();
      n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL nomul_freeze got %b exp 0", freeze); end
      n_vec++; if (WB_EN_out !== 1'b0) begin n_err++; $display("FAIL nomul_wb got %b exp 0", WB_EN_out); end
      n_vec++; if (ALU_Res !== 32'h0) begin n_err++; $display("FAIL nomul_res got %h exp 0", ALU_Res); end
      n_vec++; if ({out_valid, MEM_R_EN_out, Dest_out} !== {2'b11, 5'd8}) begin n_err++; $display("FAIL nomul_ctl got %b exp 1101000", {out_valid, MEM_R_EN_out, Dest_out}); end
      issue(4'b0000, 32'd1, 32'd1, 5'd4, 1'b1);
      step();
      n_vec++; if ({out_valid, ALU_Res} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL nomul_next got %h exp %h", {out_valid, ALU_Res}, {1'b1, 32'd2}); end
      idle_inputs();
      fz = 0;
      for (int i = 0; i < 35; i++) begin
         step();
         if (freeze !== 1'b0) fz++;
      end
      n_vec++; if (fz !== 0) begin n_err++; $display("FAIL nomul_freeze_any got %0d exp 0", fz); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_add();
      test_flush();
      test_back_to_back();
`ifdef EXE_MUL_EN
      test_mul();
      test_mul_reset();
`else
      test_mul_disabled();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
EX stage of the multicycle MIPS pipeline. It consumes the contents of the ID/EX pipeline register and executes single-cycle ALU operations. It also runs an iterative multi-cycle multiply, freezing the ID/EX register while the multiply is in progress, and drives the registered EX/MEM fields.

Parameters:
WIDTH, 32, datapath width; also the number of multiply iterations.
DEST_W, 5, register-file index width.
SH_W, 5, shift-amount width (log2 WIDTH).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  treat the current ID/EX contents as a bubble
in_valid  in  1  ID/EX holds a real instruction
EXE_CMD  in  4  operation code
Val1  in  WIDTH  operand A
Val2  in  WIDTH  operand B / shift amount
Reg2  in  WIDTH  store data
Dest  in  DEST_W  destination register
PC_in  in  WIDTH  instruction PC
MEM_R_EN  in  1  load
MEM_W_EN  in  1  store
WB_EN  in  1  writeback
freeze  out  1  hold the ID/EX register (multiply busy)
out_valid  out  1  EX/MEM holds a real instruction
ALU_Res  out  WIDTH  result
Reg2_out  out  WIDTH  store data
Dest_out  out  DEST_W  destination register
PC_out  out  WIDTH  PC passthrough
MEM_R_EN_out  out  1  load
MEM_W_EN_out  out  1  store
WB_EN_out  out  1  writeback

Behaviour:
- Reset and output state
  - clk is the single clock. rst is synchronous and active-high.
  - On rst: all outputs are 0, state is IDLE, the iteration counter is 0, freeze is 0.
  - rst overrides everything, including an in-progress multiply; the partial result is discarded.
- EXE_CMD encoding:
  - ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111.
  - SLL 1000, SRA 1001, SRL 1010, MUL 1100.
  - Any other code is a NOP: ALU_Res is 0 and the control fields pass through unchanged.
- Arithmetic rules
  - ADD and SUB wrap modulo 2^WIDTH.
  - Shifts shift Val1 by Val2[SH_W-1:0]; SRA sign-fills.
  - MUL returns the low WIDTH bits of the product (identical for signed and unsigned operands).
- Accept rule: an instruction is accepted when state==IDLE && in_valid && !flush.
- Bubble: in IDLE, if in_valid==0 or flush==1, the next edge writes a bubble (out_valid and all *_EN_out are 0; data outputs hold their previous values).
- Single-cycle ops
  - Accepted at edge T; EX/MEM outputs update at T with out_valid=1.
  - Latency is 1 cycle, throughput 1 per cycle, freeze stays 0.
- MUL FSM, states IDLE and MULT:
  - IDLE -> MULT at accept edge T: latch Val1, Val2, Reg2, Dest, PC_in and the enables; clear the accumulator; cnt=0. The EX/MEM outputs take a bubble at T.
  - In MULT, each edge performs one shift-add step and increments cnt.
  - On the edge where cnt==WIDTH-1, the outputs load the product and latched controls with out_valid=1, and state returns to IDLE.
  - While in MULT, out_valid is 0 on every edge except the completion edge.
- freeze
  - freeze = (state==MULT), registered-state driven with no combinational path from inputs.
  - It is high for exactly WIDTH cycles after the accept edge.
  - The ID/EX register advanced at T, so the instruction visible during freeze is the next one. It is consumed on the first IDLE cycle after completion.
- Other boundary conditions
  - flush while in MULT is ignored (the multiply is older than the flushing branch); in_valid is ignored while in MULT.
  - MUL with Val2==0 still takes WIDTH cycles and yields 0.

Optional Feature:
Macro EXE_MUL_EN.
- Defined: MUL is executed by the FSM and multiplier as above.
- Undefined: the FSM and multiplier are removed and freeze is tied to 0. EXE_CMD 1100 is handled as a NOP with WB_EN_out forced to 0, so no register write occurs.

Decomposition:
- Shared package mips_pkg holds:
  - the EXE_CMD localparams (EXE_ADD ... EXE_MUL);
  - the FSM state encoding (ST_IDLE, ST_MULT);
  - the WIDTH/DEST_W defaults.
- One sub-module, seq_multiplier: radix-2 shift-add iterator.
  - Inputs: start, a, b.
  - Outputs: done, product low word, with its own counter.
  - Instantiated only under EXE_MUL_EN.

Test Plan:
- ADD with Val1=5, Val2=7, WB_EN=1 -> after 1 edge: ALU_Res=12, WB_EN_out=1, out_valid=1, freeze=0 throughout.
- SUB 3-5, then SRA Val1=0x80000000 by Val2=4 on consecutive cycles -> ALU_Res=0xFFFFFFFE then 0xF8000000 on consecutive edges.
- MUL 0x0000FFFF*0x00010001 followed by ADD 1+1 -> freeze high for exactly 32 cycles with out_valid=0. Completion edge: ALU_Res=0xFFFFFFFF. Next edge: ALU_Res=2.
- flush=1 with in_valid=1 (ADD, WB_EN=1) in IDLE -> out_valid=0, WB_EN_out=0. A flush pulse during MULT does not alter the product or its out_valid.
- rst asserted at cycle 10 of a MUL -> next edge: freeze=0, all outputs 0; a subsequent ADD completes in 1 cycle.
- Build without EXE_MUL_EN, issue MUL -> freeze never rises, WB_EN_out=0, ALU_Res=0.
